// File: rtl/led_fill_drain_chaser_pkg.sv
// led_pkg: shared definitions for the LED bar blocks.
//   led_state_e : fill/drain FSM state encoding
//   CLK_HZ      : board clock rate, the default prescale for a 1 s step
package led_pkg;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        HOLD_FULL  = 2'd1,
        DRAIN      = 2'd2,
        HOLD_EMPTY = 2'd3
    } led_state_e;

    localparam int unsigned CLK_HZ = 50000000;

endpackage

// File: rtl/led_fill_drain_chaser_if.sv
// Control/status bundle between the board switches/LED bank and the chaser.
//   pause, dir                  : switch controls (master drives)
//   LED_BLUE, level, cycle_done : chaser outputs (slave drives)
interface led_fill_drain_chaser_if #(
    parameter int WIDTH = 8
) ();
    localparam int LVL_W = $clog2(WIDTH + 1);

    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] LED_BLUE;
    logic [LVL_W-1:0] level;
    logic             cycle_done;

    modport master (output pause, dir, input LED_BLUE, level, cycle_done);
    modport slave  (input pause, dir, output LED_BLUE, level, cycle_done);
endinterface

// File: rtl/led_fill_drain_chaser_tick_gen.sv
// tick_gen: free-running prescaler producing a one-clock step tick.
//   clock_50 : clock
//   rs       : async active-high reset, clears the count
//   en       : 1 = count; 0 = hold the count and suppress the tick
//   tick     : high for the cycle in which count == TICK_DIV-1 and en=1
module tick_gen
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = CLK_HZ
) (
    input  logic clock_50,
    input  logic rs,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    // Combinational so the consumer acts on the same edge the count wraps.
    assign tick    = en & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock_50 or posedge rs) begin
        if (rs) cnt_q <= '0;
        else    cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_fill_drain_chaser.sv
// led_fill_drain_chaser: thermometer bar that fills one LED per tick, holds,
// drains back, holds, and repeats. dir mirrors the bar and is only picked up
// when a new cycle starts.
//   clock_50 : clock
//   rs       : async active-high reset
//   bus      : slave side of led_fill_drain_chaser_if
//              pause (freeze), dir (mirror), LED_BLUE, level, cycle_done
module led_fill_drain_chaser
    import led_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter int unsigned TICK_DIV   = CLK_HZ,
    parameter int          HOLD_TICKS = 2
) (
    input  logic                    clock_50,
    input  logic                    rs,
    led_fill_drain_chaser_if.slave  bus
);
    localparam int LVL_W = $clog2(WIDTH + 1);
    localparam int HC_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] ST_FILL       = FILL;
    localparam logic [1:0] ST_HOLD_FULL  = HOLD_FULL;
    localparam logic [1:0] ST_DRAIN      = DRAIN;
    localparam logic [1:0] ST_HOLD_EMPTY = HOLD_EMPTY;

    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(WIDTH);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_TICKS - 1);

    logic             tick;
    logic             en;
    logic [1:0]       state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] therm, therm_rev;

    assign en = ~bus.pause;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock_50 (clock_50),
        .rs       (rs),
        .en       (en),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_FILL: begin
                    // Saturating step keeps level within 0..WIDTH regardless of state.
                    level_d = (level_q == LVL_MAX) ? level_q : level_q + 1'b1;
                    if (level_d == LVL_MAX) begin
                        state_d = ST_HOLD_FULL;
                        hold_d  = '0;
                    end
                end
                ST_HOLD_FULL: begin
                    if (hold_q == HOLD_LAST) state_d = ST_DRAIN;
                    else                     hold_d  = hold_q + 1'b1;
                end
                ST_DRAIN: begin
                    level_d = (level_q == '0) ? level_q : level_q - 1'b1;
                    if (level_d == '0) begin
                        state_d = ST_HOLD_EMPTY;
                        hold_d  = '0;
                    end
                end
                default: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_FILL;
                        dir_d   = bus.dir;
                        done_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // LEDs are driven from the next level so they move on the tick edge itself.
    always_comb begin
        therm = '0;
        for (int i = 0; i < WIDTH; i++) therm[i] = (LVL_W'(i) < level_d);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign therm_rev[g] = therm[WIDTH-1-g];
    end

    always_comb begin
        led_d = dir_d ? therm_rev : therm;
    end

    always_ff @(posedge clock_50 or posedge rs) begin
        if (rs) begin
            state_q <= ST_FILL;
            level_q <= '0;
            hold_q  <= '0;
            dir_q   <= bus.dir;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign bus.LED_BLUE   = led_q;
    assign bus.level      = level_q;
    assign bus.cycle_done = done_q;
endmodule
